// File: rtl/caliptra_prim_intr_rx.sv
// Receive-side interrupt controller with per-source gateways and priority/threshold arbitration.
// The CPU sees one registered request and uses a claim/complete handshake.
module caliptra_prim_intr_rx #(
  parameter int unsigned NumSrc = 8,
  parameter int unsigned PrioW  = 2,
  localparam int unsigned IdW   = $clog2(NumSrc + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumSrc-1:0]       intr_i,
  input  logic [NumSrc-1:0]       src_en_i,
  input  logic [NumSrc*PrioW-1:0] src_prio_i,
  input  logic [PrioW-1:0]        threshold_i,
  input  logic                    claim_i,
  input  logic                    complete_i,
  input  logic [IdW-1:0]          complete_id_i,
  output logic                    irq_o,
  output logic [IdW-1:0]          irq_id_o,
  output logic                    claim_valid_o,
  output logic [IdW-1:0]          claim_id_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PENDING   = 2'd1,
    INSERVICE = 2'd2
  } gw_state_e;

  gw_state_e        state_q [NumSrc];
  gw_state_e        state_d [NumSrc];
  logic             irq_q, irq_d;
  logic [IdW-1:0]   irq_id_q, irq_id_d;
  logic             claim_valid_q;
  logic [IdW-1:0]   claim_id_q;
  logic [PrioW-1:0] best_prio;

  // Gateway next-state, then arbitrate over the next-state vector so a claimed
  // source is already excluded from the request registered on the claim edge.
  always_comb begin
    irq_id_d  = '0;
    best_prio = threshold_i;
    for (int k = 0; k < int'(NumSrc); k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        IDLE:      if (intr_i[k] && src_en_i[k]) state_d[k] = PENDING;
        PENDING:   if (claim_i && (irq_id_q == IdW'(k + 1))) state_d[k] = INSERVICE;
        INSERVICE: if (complete_i && (complete_id_i == IdW'(k + 1))) state_d[k] = IDLE;
        default:   state_d[k] = IDLE;
      endcase
      // Strict compare: starting from the threshold enforces prio > threshold,
      // and ascending scan keeps the lowest index on ties.
      if ((state_d[k] == PENDING) && src_en_i[k] &&
          (src_prio_i[k*PrioW +: PrioW] > best_prio)) begin
        best_prio = src_prio_i[k*PrioW +: PrioW];
        irq_id_d  = IdW'(k + 1);
      end
    end
    irq_d = (irq_id_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(NumSrc); k++) state_q[k] <= IDLE;
      irq_q         <= 1'b0;
      irq_id_q      <= '0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
    end else begin
      for (int k = 0; k < int'(NumSrc); k++) state_q[k] <= state_d[k];
      irq_q         <= irq_d;
      irq_id_q      <= irq_id_d;
      claim_valid_q <= claim_i;
      if (claim_i) claim_id_q <= irq_id_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (irq_q == (irq_id_q != '0));
      assert ((NumSrc >= 1) && (NumSrc <= 63));
    end
  end

  assign irq_o         = irq_q;
  assign irq_id_o      = irq_id_q;
  assign claim_valid_o = claim_valid_q;
  assign claim_id_o    = claim_id_q;

endmodule

// File: tb/tb_caliptra_prim_intr_rx.sv
// Bench for caliptra_prim_intr_rx: fixed vector table, corner-case sequences and
// randomized traffic against a set-based reference model.
module tb_caliptra_prim_intr_rx;

  localparam int unsigned NS = 8;
  localparam int unsigned PW = 2;
  localparam int unsigned IW = 4;

  logic          clk;
  logic          rst_i;
  logic [NS-1:0] intr_i, src_en_i;
  logic [NS*PW-1:0] src_prio_i;
  logic [PW-1:0] threshold_i;
  logic          claim_i, complete_i;
  logic [IW-1:0] complete_id_i;
  logic          irq_o, claim_valid_o;
  logic [IW-1:0] irq_id_o, claim_id_o;

  caliptra_prim_intr_rx #(.NumSrc(NS), .PrioW(PW)) dut (
    .clk_i(clk), .rst_i(rst_i), .intr_i(intr_i), .src_en_i(src_en_i),
    .src_prio_i(src_prio_i), .threshold_i(threshold_i), .claim_i(claim_i),
    .complete_i(complete_i), .complete_id_i(complete_id_i), .irq_o(irq_o),
    .irq_id_o(irq_id_o), .claim_valid_o(claim_valid_o), .claim_id_o(claim_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit [7:0]    intr;
    bit [7:0]    en;
    bit [15:0]   prio;
    bit [1:0]    thr;
    bit          claim;
    bit          comp;
    bit [3:0]    cid;
    bit          e_irq;
    int          e_id;
    bit          e_cv;
    int          e_cid;
  } vec_t;

  vec_t tbl [9];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: sets of pending / in-service sources plus output registers.
  bit pend [NS];
  bit insvc [NS];
  bit m_irq, m_cv;
  int m_id, m_cid;

  function automatic int prio_of(int k);
    return int'((src_prio_i >> (k * PW)) & 16'(3));
  endfunction

  function automatic void model_step();
    int maxp, win;
    if (rst_i) begin
      for (int k = 0; k < NS; k++) begin pend[k] = 0; insvc[k] = 0; end
      m_irq = 0; m_id = 0; m_cv = 0; m_cid = 0;
      return;
    end
    for (int k = 0; k < NS; k++) begin
      if (insvc[k]) begin
        if (complete_i && int'(complete_id_i) == k + 1) insvc[k] = 0;
      end else if (pend[k]) begin
        if (claim_i && m_id == k + 1) begin pend[k] = 0; insvc[k] = 1; end
      end else if (intr_i[k] && src_en_i[k]) begin
        pend[k] = 1;
      end
    end
    m_cv = claim_i;
    if (claim_i) m_cid = m_id;
    maxp = -1;
    for (int k = 0; k < NS; k++)
      if (pend[k] && src_en_i[k] && prio_of(k) > maxp) maxp = prio_of(k);
    win = 0;
    if (maxp > int'(threshold_i))
      for (int k = NS - 1; k >= 0; k--)
        if (pend[k] && src_en_i[k] && prio_of(k) == maxp) win = k + 1;
    m_id  = win;
    m_irq = (win != 0);
  endfunction

  task automatic tick(input string name);
    model_step();
    @(posedge clk);
    #1;
    n_vec++;
    if (irq_o !== m_irq || int'(irq_id_o) != m_id || claim_valid_o !== m_cv ||
        int'(claim_id_o) != m_cid || $isunknown({irq_o, irq_id_o, claim_valid_o, claim_id_o})) begin
      n_err++;
      $display("FAIL %s model: got irq=%0b id=%0d cv=%0b cid=%0d, expected irq=%0b id=%0d cv=%0b cid=%0d",
               name, irq_o, irq_id_o, claim_valid_o, claim_id_o, m_irq, m_id, m_cv, m_cid);
    end
  endtask

  task automatic expect_out(input string name, input bit e_irq, input int e_id,
                            input bit e_cv, input int e_cid);
    n_vec++;
    if (irq_o !== e_irq || int'(irq_id_o) != e_id || claim_valid_o !== e_cv ||
        int'(claim_id_o) != e_cid) begin
      n_err++;
      $display("FAIL %s: got irq=%0b id=%0d cv=%0b cid=%0d, expected irq=%0b id=%0d cv=%0b cid=%0d",
               name, irq_o, irq_id_o, claim_valid_o, claim_id_o, e_irq, e_id, e_cv, e_cid);
    end
  endtask

  task automatic idle_inputs();
    rst_i = 0; intr_i = '0; claim_i = 0; complete_i = 0; complete_id_i = '0;
  endtask

  task automatic do_complete(input int id, input string name);
    complete_i = 1; complete_id_i = IW'(id);
    tick(name);
    complete_i = 0; complete_id_i = '0;
  endtask

  task automatic do_claim(input string name);
    claim_i = 1;
    tick(name);
    claim_i = 0;
  endtask

  initial begin
    rst_i = 1; intr_i = '0; src_en_i = '1; src_prio_i = '0; threshold_i = '0;
    claim_i = 0; complete_i = 0; complete_id_i = '0;

    // rst intr en prio thr claim comp cid | irq id cv cid
    tbl[0] = '{1, 8'h00, 8'hFF, 16'h0010, 2'd0, 0, 0, 4'd0, 0, 0, 0, 0};
    tbl[1] = '{0, 8'h04, 8'hFF, 16'h0010, 2'd0, 0, 0, 4'd0, 1, 3, 0, 0};
    tbl[2] = '{0, 8'h00, 8'hFF, 16'h0010, 2'd0, 1, 0, 4'd0, 0, 0, 1, 3};
    tbl[3] = '{0, 8'h00, 8'hFF, 16'h0010, 2'd0, 0, 1, 4'd3, 0, 0, 0, 3};
    tbl[4] = '{0, 8'h12, 8'hFF, 16'h0208, 2'd0, 0, 0, 4'd0, 1, 2, 0, 3};
    tbl[5] = '{0, 8'h00, 8'hFF, 16'h0208, 2'd0, 1, 0, 4'd0, 1, 5, 1, 2};
    tbl[6] = '{0, 8'h00, 8'hFF, 16'h0208, 2'd0, 1, 0, 4'd0, 0, 0, 1, 5};
    tbl[7] = '{0, 8'h00, 8'hFF, 16'h0208, 2'd0, 0, 1, 4'd2, 0, 0, 0, 5};
    tbl[8] = '{0, 8'h00, 8'hFF, 16'h0208, 2'd0, 0, 1, 4'd5, 0, 0, 0, 5};

    for (int i = 0; i < 9; i++) begin
      rst_i = tbl[i].rst; intr_i = tbl[i].intr; src_en_i = tbl[i].en;
      src_prio_i = tbl[i].prio; threshold_i = tbl[i].thr; claim_i = tbl[i].claim;
      complete_i = tbl[i].comp; complete_id_i = tbl[i].cid;
      tick($sformatf("table%0d", i));
      expect_out($sformatf("table%0d", i), tbl[i].e_irq, tbl[i].e_id, tbl[i].e_cv, tbl[i].e_cid);
    end
    idle_inputs();

    // Threshold gating: src0 prio 2, src3 prio 3.
    threshold_i = 2; src_prio_i = 16'h00C2; intr_i = 8'h09;
    tick("thr_pend");           expect_out("thr_id4", 1, 4, 0, 5);
    intr_i = 0; threshold_i = 3;
    tick("thr_raise");          expect_out("thr_masked", 0, 0, 0, 5);
    threshold_i = 0;
    tick("thr_lower");          expect_out("thr_still_pending", 1, 4, 0, 5);
    do_claim("thr_claim4");     expect_out("thr_next_id1", 1, 1, 1, 4);
    do_claim("thr_claim1");     expect_out("thr_none", 0, 0, 1, 1);
    do_complete(4, "thr_c4");
    do_complete(1, "thr_c1");

    // In-service source ignores its held-high line until completed.
    src_prio_i = 16'h0400; intr_i = 8'h20;
    tick("ins_pend");           expect_out("ins_id6", 1, 6, 0, 1);
    do_claim("ins_claim");      expect_out("ins_claimed", 0, 0, 1, 6);
    for (int i = 0; i < 3; i++) tick("ins_hold");
    expect_out("ins_no_repend", 0, 0, 0, 6);
    do_complete(7, "ins_c7");   expect_out("ins_c7_ignored", 0, 0, 0, 6);
    tick("ins_c7_after");       expect_out("ins_c7_still", 0, 0, 0, 6);
    do_complete(6, "ins_c6");   expect_out("ins_c6_idle", 0, 0, 0, 6);
    tick("ins_repend");         expect_out("ins_repend_id6", 1, 6, 0, 6);
    intr_i = 0;
    do_claim("ins_claim2");
    do_complete(6, "ins_c6b");

    // Empty claim, then claim + complete of different IDs in one cycle.
    do_claim("empty_claim");    expect_out("empty_claim", 0, 0, 1, 0);
    src_prio_i = 16'h0005; intr_i = 8'h01;
    tick("cc_pend0");
    intr_i = 0;
    do_claim("cc_claim0");
    intr_i = 8'h02;
    tick("cc_pend1");           expect_out("cc_id2", 1, 2, 0, 1);
    intr_i = 0; claim_i = 1; complete_i = 1; complete_id_i = 4'd1;
    tick("cc_both");            expect_out("cc_both", 0, 0, 1, 2);
    idle_inputs();
    do_complete(2, "cc_c2");
    do_complete(1, "cc_c1_again");
    expect_out("cc_quiet", 0, 0, 0, 2);

    // Reset mid-service: src0, src1 in service, src2 pending.
    src_prio_i = 16'h0015; intr_i = 8'h07;
    tick("rs_pend");
    intr_i = 0;
    do_claim("rs_claim_a");
    do_claim("rs_claim_b");     expect_out("rs_one_pending", 1, 3, 1, 2);
    rst_i = 1;
    tick("rs_reset");           expect_out("rs_zero", 0, 0, 0, 0);
    rst_i = 0;
    for (int i = 0; i < 3; i++) tick("rs_after");
    expect_out("rs_quiet", 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_i         = ($urandom_range(199) == 0);
      intr_i        = NS'($urandom) & NS'($urandom);
      src_en_i      = ($urandom_range(9) == 0) ? NS'($urandom) : '1;
      if ($urandom_range(15) == 0) src_prio_i = (NS*PW)'($urandom);
      if ($urandom_range(31) == 0) threshold_i = PW'($urandom_range(2));
      claim_i       = ($urandom_range(3) == 0);
      complete_i    = ($urandom_range(2) == 0);
      complete_id_i = IW'($urandom_range(9));
      tick("random");
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
